// File: rtl/sparc_ctrl_pkg.sv
// Shared control constants and trap-sequencer state encoding.
// The ERROR state is present only when TRAP_ERROR_MODE_EN is defined.
package sparc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SAVE_PC  = 3'd2,
    SAVE_NPC = 3'd3,
    WR_PSR   = 3'd4,
    JUMP     = 3'd5
`ifdef TRAP_ERROR_MODE_EN
    ,
    ERROR    = 3'd6
`endif
  } trap_state_e;

  localparam logic [5:0] ALU_OP_PASS_A   = 6'h10;
  // PSR update for trap entry: S=1, ET=0, CWP decremented
  localparam logic [5:0] ALU_OP_TRAP_PSR = 6'h2c;
  localparam logic [1:0] ALUA_SEL_PC     = 2'd1;
  localparam logic [1:0] ALUA_SEL_NPC    = 2'd2;
  localparam logic [1:0] PCIN_SEL_TBR    = 2'd3;

  function automatic logic [7:0] tt_onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

endpackage

// File: rtl/trap_priority_enc.sv
// Lowest-index-wins priority encoder over the eight trap sources.
module trap_priority_enc (
  input  logic [7:0] mask,
  output logic       valid,
  output logic [2:0] idx
);

  always_comb begin
    valid = |mask;
    idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap entry sequencer: latches pending requests, then walks the fixed
// save/PSR/jump sequence. Optional ERROR trapping via TRAP_ERROR_MODE_EN.
//
// state    | meaning
// IDLE     | waiting for pending request with ET=1
// LATCH    | load TBR with captured tt
// SAVE_PC  | write PC into SAVE_PC_REG
// SAVE_NPC | write nPC into SAVE_NPC_REG
// WR_PSR   | PSR update for trap entry
// JUMP     | PC/nPC from TBR, acknowledge source
// ERROR    | request seen with ET=0 (optional); left only by RESET
module trap_sequencer
  import sparc_ctrl_pkg::*;
#(
  parameter logic [4:0] SAVE_PC_REG  = 5'd17,
  parameter logic [4:0] SAVE_NPC_REG = 5'd18
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic [7:0] trap_req,
  input  logic       ET,
  output logic [7:0] trap_ack,
  output logic [2:0] tt,
  output logic       TBR_enable,
  output logic       TBR_Mux_select,
  output logic       register_file_enable,
  output logic [4:0] in_PC,
  output logic [1:0] ALUA_Mux_select,
  output logic [5:0] ALU_op,
  output logic       PSR_Enable,
  output logic       PC_enable,
  output logic       NPC_enable,
  output logic [1:0] PC_In_Mux_select,
  output logic       trap_busy,
  output logic       error_mode
);

  trap_state_e state, state_next;
  logic [7:0]  pending;
  logic        pend_valid;
  logic [2:0]  pend_idx;
  logic        capture;

  trap_priority_enc u_enc (
    .mask  (pending),
    .valid (pend_valid),
    .idx   (pend_idx)
  );

  assign capture = (state == IDLE) && (state_next == LATCH);

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state   <= IDLE;
      pending <= 8'd0;
      tt      <= 3'd0;
    end else begin
      state   <= state_next;
      // a new request wins over a same-cycle ack of the same bit
      pending <= (pending & ~trap_ack) | trap_req;
      if (capture) tt <= pend_idx;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pend_valid && ET) state_next = LATCH;
`ifdef TRAP_ERROR_MODE_EN
        else if (pend_valid) state_next = ERROR;
`endif
      end
      LATCH:    state_next = SAVE_PC;
      SAVE_PC:  state_next = SAVE_NPC;
      SAVE_NPC: state_next = WR_PSR;
      WR_PSR:   state_next = JUMP;
      JUMP:     state_next = IDLE;
`ifdef TRAP_ERROR_MODE_EN
      ERROR:    state_next = ERROR;
`endif
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    trap_ack             = 8'd0;
    TBR_enable           = 1'b0;
    TBR_Mux_select       = 1'b0;
    register_file_enable = 1'b0;
    in_PC                = 5'd0;
    ALUA_Mux_select      = 2'd0;
    ALU_op               = 6'd0;
    PSR_Enable           = 1'b0;
    PC_enable            = 1'b0;
    NPC_enable           = 1'b0;
    PC_In_Mux_select     = 2'd0;
    case (state)
      LATCH: begin
        TBR_enable     = 1'b1;
        TBR_Mux_select = 1'b1;
      end
      SAVE_PC: begin
        ALUA_Mux_select      = ALUA_SEL_PC;
        ALU_op               = ALU_OP_PASS_A;
        register_file_enable = 1'b1;
        in_PC                = SAVE_PC_REG;
      end
      SAVE_NPC: begin
        ALUA_Mux_select      = ALUA_SEL_NPC;
        ALU_op               = ALU_OP_PASS_A;
        register_file_enable = 1'b1;
        in_PC                = SAVE_NPC_REG;
      end
      WR_PSR: begin
        PSR_Enable = 1'b1;
        ALU_op     = ALU_OP_TRAP_PSR;
      end
      JUMP: begin
        PC_In_Mux_select = PCIN_SEL_TBR;
        PC_enable        = 1'b1;
        NPC_enable       = 1'b1;
        trap_ack         = tt_onehot(tt);
      end
      default: ;
    endcase
  end

  assign trap_busy = (state != IDLE);

`ifdef TRAP_ERROR_MODE_EN
  assign error_mode = (state == ERROR);
`else
  assign error_mode = 1'b0;
`endif

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: directed table, corner sequences,
// and random traffic against a phase-count reference model.
module tb_trap_sequencer;
  import sparc_ctrl_pkg::*;

  logic       Clk = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] trap_req = 8'd0;
  logic       ET = 1'b0;

  logic [7:0] trap_ack;
  logic [2:0] tt;
  logic       TBR_enable, TBR_Mux_select, register_file_enable;
  logic [4:0] in_PC;
  logic [1:0] ALUA_Mux_select;
  logic [5:0] ALU_op;
  logic       PSR_Enable, PC_enable, NPC_enable;
  logic [1:0] PC_In_Mux_select;
  logic       trap_busy, error_mode;

  trap_sequencer dut (
    .Clk                  (Clk),
    .RESET                (RESET),
    .trap_req             (trap_req),
    .ET                   (ET),
    .trap_ack             (trap_ack),
    .tt                   (tt),
    .TBR_enable           (TBR_enable),
    .TBR_Mux_select       (TBR_Mux_select),
    .register_file_enable (register_file_enable),
    .in_PC                (in_PC),
    .ALUA_Mux_select      (ALUA_Mux_select),
    .ALU_op               (ALU_op),
    .PSR_Enable           (PSR_Enable),
    .PC_enable            (PC_enable),
    .NPC_enable           (NPC_enable),
    .PC_In_Mux_select     (PC_In_Mux_select),
    .trap_busy            (trap_busy),
    .error_mode           (error_mode)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // model: phase 0 idle, 1..5 position in the trap sequence, 6 error
  int         m_phase = 0;
  int         m_tt = 0;
  logic [7:0] m_pend = 8'd0;
  logic [7:0] ack_log[$];

  logic [33:0] act;
  assign act = {trap_ack, tt, TBR_enable, TBR_Mux_select, register_file_enable, in_PC,
                ALUA_Mux_select, ALU_op, PSR_Enable, PC_enable, NPC_enable,
                PC_In_Mux_select, trap_busy, error_mode};

  typedef struct {
    logic [7:0] req;
    logic       et;
    logic [7:0] ack;
    logic [4:0] inpc;
    logic       rfe;
    logic       tbe;
    logic       busy;
    logic [2:0] ttv;
  } vec_t;

  vec_t tbl[7];

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [33:0] expect_vec(int ph, int t);
    logic [7:0] ack = 8'd0;
    logic       tbe = 1'b0, tbs = 1'b0, rfe = 1'b0;
    logic [4:0] inpc = 5'd0;
    logic [1:0] alua = 2'd0;
    logic [5:0] op = 6'd0;
    logic       psr = 1'b0, pce = 1'b0, npce = 1'b0;
    logic [1:0] pcin = 2'd0;
    logic       busy, err = 1'b0;
    case (ph)
      1: begin tbe = 1'b1; tbs = 1'b1; end
      2: begin alua = ALUA_SEL_PC; op = ALU_OP_PASS_A; rfe = 1'b1; inpc = 5'd17; end
      3: begin alua = ALUA_SEL_NPC; op = ALU_OP_PASS_A; rfe = 1'b1; inpc = 5'd18; end
      4: begin psr = 1'b1; op = ALU_OP_TRAP_PSR; end
      5: begin pcin = PCIN_SEL_TBR; pce = 1'b1; npce = 1'b1; ack = 8'd1 << t; end
      6: err = 1'b1;
      default: ;
    endcase
    busy = (ph != 0);
    return {ack, 3'(t), tbe, tbs, rfe, inpc, alua, op, psr, pce, npce, pcin, busy, err};
  endfunction

  task automatic check_vec(string name, logic [33:0] a, logic [33:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, a, e, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] ackm;
    ackm = (m_phase == 5) ? (8'd1 << m_tt) : 8'd0;
    if (m_phase == 0) begin
      if (m_pend != 0 && ET) begin
        m_phase = 1;
        m_tt = lowest(m_pend);
      end
`ifdef TRAP_ERROR_MODE_EN
      else if (m_pend != 0) m_phase = 6;
`endif
    end else if (m_phase >= 1 && m_phase <= 4) m_phase++;
    else if (m_phase == 5) m_phase = 0;
    m_pend = (m_pend & ~ackm) | trap_req;
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    if (trap_ack != 0) ack_log.push_back(trap_ack);
    check_vec($sformatf("cycle_ph%0d", m_phase), act, expect_vec(m_phase, m_tt));
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_tt = 0;
    m_pend = 8'd0;
  endtask

  task automatic apply_reset();
    RESET = 1'b0;
    #1;
    model_reset();
    check_vec("reset_async", act, 34'd0);
    @(posedge Clk);
    #1;
    check_vec("reset_hold", act, 34'd0);
    RESET = 1'b1;
  endtask

  initial begin
    tbl[0] = '{8'h10, 1'b1, 8'h00, 5'd0,  1'b0, 1'b0, 1'b0, 3'd0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 5'd0,  1'b0, 1'b1, 1'b1, 3'd4};
    tbl[2] = '{8'h00, 1'b1, 8'h00, 5'd17, 1'b1, 1'b0, 1'b1, 3'd4};
    tbl[3] = '{8'h00, 1'b1, 8'h00, 5'd18, 1'b1, 1'b0, 1'b1, 3'd4};
    tbl[4] = '{8'h00, 1'b1, 8'h00, 5'd0,  1'b0, 1'b0, 1'b1, 3'd4};
    tbl[5] = '{8'h00, 1'b1, 8'h10, 5'd0,  1'b0, 1'b0, 1'b1, 3'd4};
    tbl[6] = '{8'h00, 1'b1, 8'h00, 5'd0,  1'b0, 1'b0, 1'b0, 3'd4};

    #2;
    apply_reset();
    ET = 1'b1;
    repeat (2) tick();

    // single request, cycle-exact table
    for (int i = 0; i < 7; i++) begin
      trap_req = tbl[i].req;
      ET = tbl[i].et;
      tick();
      check_vec($sformatf("tbl_row%0d", i),
                {26'd0, trap_ack, in_PC, register_file_enable, TBR_enable, trap_busy, tt},
                {26'd0, tbl[i].ack, tbl[i].inpc, tbl[i].rfe, tbl[i].tbe, tbl[i].busy, tbl[i].ttv});
    end

    // two sources in one cycle: lower index first, then the other without re-request
    ack_log.delete();
    trap_req = 8'h24; tick(); trap_req = 8'h00;
    repeat (14) tick();
    check_int("dual_ack_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check_int("dual_ack_first", int'(ack_log[0]), 8'h04);
      check_int("dual_ack_second", int'(ack_log[1]), 8'h20);
    end

    // new request during SAVE_NPC waits for the running sequence
    ack_log.delete();
    trap_req = 8'h08; tick(); trap_req = 8'h00;
    for (int i = 0; i < 10 && !(register_file_enable && in_PC == 5'd18); i++) tick();
    check_int("reach_save_npc", int'(in_PC), 18);
    trap_req = 8'h01; tick(); trap_req = 8'h00;
    repeat (12) tick();
    check_int("late_ack_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) begin
      check_int("late_ack_first", int'(ack_log[0]), 8'h08);
      check_int("late_ack_second", int'(ack_log[1]), 8'h01);
    end

    // request held through its own JUMP re-arms
    ack_log.delete();
    trap_req = 8'h40;
    for (int i = 0; i < 12 && trap_ack == 8'h00; i++) tick();
    check_int("held_first_ack", int'(trap_ack), 8'h40);
    tick();
    trap_req = 8'h00;
    repeat (12) tick();
    check_int("held_ack_count", ack_log.size(), 2);
    if (ack_log.size() >= 2) check_int("held_ack_second", int'(ack_log[1]), 8'h40);

    // reset in SAVE_PC aborts and discards pending
    trap_req = 8'h02; tick(); trap_req = 8'h06;
    tick(); trap_req = 8'h00;
    tick();
    check_int("abort_in_save_pc", int'(in_PC), 17);
    #2;
    apply_reset();
    repeat (4) tick();
    check_int("abort_stays_idle", int'(trap_busy), 0);

    // ET=0 with pending request
    ET = 1'b0;
    trap_req = 8'h80; tick(); trap_req = 8'h00;
    repeat (6) tick();
`ifdef TRAP_ERROR_MODE_EN
    check_int("et0_error_mode", int'(error_mode), 1);
    ET = 1'b1;
    repeat (3) tick();
    check_int("error_sticky", int'(error_mode), 1);
    apply_reset();
    tick();
`else
    check_int("et0_no_activity", int'(trap_busy), 0);
    ack_log.delete();
    ET = 1'b1;
    repeat (8) tick();
    check_int("et1_ack_count", ack_log.size(), 1);
    if (ack_log.size() >= 1) check_int("et1_ack_val", int'(ack_log[0]), 8'h80);
    check_int("et1_tt", int'(tt), 7);
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      trap_req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
`ifdef TRAP_ERROR_MODE_EN
      ET = 1'b1;
`else
      ET = ($urandom_range(0, 7) != 0);
`endif
      tick();
    end
    trap_req = 8'h00;
    ET = 1'b1;
    repeat (20) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
